// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath strobes, muxes and the alu_op/func pair.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to make an illegal opcode
// trap (sticky flag, FSM parked until rst); otherwise it is a 1-cycle NOP.
module rv_multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  func,
    output logic        illegal_instr,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        ILLEGAL  = 4'd14
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [3:0]  func_r;
    logic [3:0]  func_i;
    logic        unused_instr_bits;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign func_r  = {instr[30], funct3};
    // Only SRAI uses funct7[5]; ADDI with imm[10] set must not turn into SUB
    assign func_i  = {(funct3 == 3'b101) & instr[30], funct3};
    assign state_o = 4'(state);
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // State register, next-state sequencing and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= state_t'(RESET_STATE);
            illegal_instr <= 1'b0;
        end else begin
            case (state)
                FETCH:    if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_R:      state <= EXEC_R;
                        OP_IMM:    state <= EXEC_I;
                        OP_LOAD:   state <= MEM_ADDR;
                        OP_STORE:  state <= MEM_ADDR;
                        OP_BRANCH: state <= BRANCH;
                        OP_JAL:    state <= JAL;
                        OP_JALR:   state <= JALR;
                        OP_LUI:    state <= LUI;
                        OP_AUIPC:  state <= AUIPC;
                        default: begin
                            state <= ILLEGAL;
`ifdef CTRL_ILLEGAL_TRAP_EN
                            illegal_instr <= 1'b1;
`endif
                        end
                    endcase
                end
                EXEC_R:   state <= ALU_WB;
                EXEC_I:   state <= ALU_WB;
                ALU_WB:   state <= FETCH;
                MEM_ADDR: state <= (opcode == OP_STORE) ? MEM_WR : MEM_RD;
                MEM_RD:   if (mem_ready) state <= MEM_WB;
                MEM_WB:   state <= FETCH;
                MEM_WR:   if (mem_ready) state <= FETCH;
                BRANCH:   state <= FETCH;
                JAL:      state <= FETCH;
                JALR:     state <= FETCH;
                LUI:      state <= FETCH;
                AUIPC:    state <= ALU_WB;
`ifdef CTRL_ILLEGAL_TRAP_EN
                ILLEGAL:  state <= ILLEGAL;
`else
                ILLEGAL:  state <= FETCH;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore output decode; FETCH gates its IR/PC loads on mem_ready
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        func          = 4'b0000;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_op    = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            EXEC_R: begin
                alu_op = 2'b10;
                func   = func_r;
            end
            EXEC_I: begin
                alu_op    = 2'b10;
                alu_src_b = 2'b01;
                func      = func_i;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                // Keep the ALU computing what the preceding execute state set up
                case (opcode)
                    OP_R: begin
                        alu_op = 2'b10;
                        func   = func_r;
                    end
                    OP_IMM: begin
                        alu_op    = 2'b10;
                        alu_src_b = 2'b01;
                        func      = func_i;
                    end
                    OP_AUIPC: begin
                        alu_op    = 2'b01;
                        alu_src_a = 2'b10;
                        alu_src_b = 2'b01;
                    end
                    default: ;
                endcase
            end
            MEM_ADDR, MEM_RD: begin
                alu_op    = 2'b01;
                alu_src_b = 2'b01;
                mem_read  = (state == MEM_RD);
            end
            MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
            end
            MEM_WR:   mem_write = 1'b1;
            BRANCH: begin
                alu_op        = 2'b11;
                func          = {1'b0, funct3};
                pc_write_cond = 1'b1;
                pc_src        = 2'b01;
            end
            JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_src    = 2'b01;
            end
            JALR: begin
                alu_op    = 2'b01;
                alu_src_b = 2'b01;
                reg_write = 1'b1;
                wb_sel    = 2'b10;
                pc_write  = 1'b1;
                pc_src    = 2'b10;
            end
            LUI: begin
                reg_write = 1'b1;
                wb_sel    = 2'b11;
            end
            AUIPC: begin
                alu_op    = 2'b01;
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized scoreboard bench for rv_multicycle_ctrl.
// Stimulus walks each instruction through its expected phase list and queues
// the expected output vector per cycle; a negedge monitor pops and compares.
module tb_rv_multicycle_ctrl;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3,
                   P_ALU_WB = 4, P_MEM_ADDR = 5, P_MEM_RD = 6, P_MEM_WB = 7,
                   P_MEM_WR = 8, P_BRANCH = 9, P_JAL = 10, P_JALR = 11,
                   P_LUI = 12, P_AUIPC = 13, P_ILLEGAL = 14;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic [1:0] wb;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [3:0] fn;
        logic       ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
    logic        illegal_instr;
    logic [1:0]  pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
    logic [3:0]  func, state_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    vec_t exp_q[$];
    int   ph_q[$];

    rv_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .func(func),
        .illegal_instr(illegal_instr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Reference: what the control word must be in a given phase of an instruction
    function automatic vec_t model(int ph, logic [31:0] ins, logic mr);
        vec_t v;
        logic [2:0] f3;
        logic [6:0] op;
        logic [3:0] fr, fi;
        f3 = ins[14:12];
        op = ins[6:0];
        fr = {ins[30], f3};
        fi = {(f3 == 3'b101) ? ins[30] : 1'b0, f3};
        v = '0;
        v.st = 4'(ph);
        case (ph)
            P_FETCH:   begin v.mrd = 1; v.a = 2'b01; v.b = 2'b10; v.aop = 2'b01; v.irw = mr; v.pcw = mr; end
            P_EXEC_R:  begin v.aop = 2'b10; v.fn = fr; end
            P_EXEC_I:  begin v.aop = 2'b10; v.b = 2'b01; v.fn = fi; end
            P_ALU_WB: begin
                v.rw = 1;
                if (op == 7'b0110011) begin v.aop = 2'b10; v.fn = fr; end
                else if (op == 7'b0010011) begin v.aop = 2'b10; v.b = 2'b01; v.fn = fi; end
                else begin v.aop = 2'b01; v.a = 2'b10; v.b = 2'b01; end
            end
            P_MEM_ADDR: begin v.aop = 2'b01; v.b = 2'b01; end
            P_MEM_RD:  begin v.mrd = 1; v.aop = 2'b01; v.b = 2'b01; end
            P_MEM_WB:  begin v.rw = 1; v.wb = 2'b01; end
            P_MEM_WR:  v.mwr = 1;
            P_BRANCH:  begin v.aop = 2'b11; v.fn = {1'b0, f3}; v.pcwc = 1; v.pcs = 2'b01; end
            P_JAL:     begin v.rw = 1; v.wb = 2'b10; v.pcw = 1; v.pcs = 2'b01; end
            P_JALR:    begin v.aop = 2'b01; v.b = 2'b01; v.rw = 1; v.wb = 2'b10; v.pcw = 1; v.pcs = 2'b10; end
            P_LUI:     begin v.rw = 1; v.wb = 2'b11; end
            P_AUIPC:   begin v.aop = 2'b01; v.a = 2'b10; v.b = 2'b01; end
            P_ILLEGAL: v.ill = TRAP;
            default: ;
        endcase
        return v;
    endfunction

    // One clock of stimulus: drive inputs, queue the expectation for this cycle
    task automatic step(int ph, logic [31:0] ins, logic mr);
        instr     = ins;
        mem_ready = mr;
        exp_q.push_back(model(ph, ins, mr));
        ph_q.push_back(ph);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Full instruction: FETCH with fw wait cycles, then the class-specific path
    task automatic run_instr(logic [31:0] ins, int fw, int mw);
        logic [6:0] op;
        op = ins[6:0];
        for (int i = 0; i < fw; i++) step(P_FETCH, ins, 1'b0);
        step(P_FETCH, ins, 1'b1);
        step(P_DECODE, ins, rnd_bit());
        case (op)
            7'b0110011: begin step(P_EXEC_R, ins, rnd_bit()); step(P_ALU_WB, ins, rnd_bit()); end
            7'b0010011: begin step(P_EXEC_I, ins, rnd_bit()); step(P_ALU_WB, ins, rnd_bit()); end
            7'b0000011: begin
                step(P_MEM_ADDR, ins, rnd_bit());
                for (int i = 0; i < mw; i++) step(P_MEM_RD, ins, 1'b0);
                step(P_MEM_RD, ins, 1'b1);
                step(P_MEM_WB, ins, rnd_bit());
            end
            7'b0100011: begin
                step(P_MEM_ADDR, ins, rnd_bit());
                for (int i = 0; i < mw; i++) step(P_MEM_WR, ins, 1'b0);
                step(P_MEM_WR, ins, 1'b1);
            end
            7'b1100011: step(P_BRANCH, ins, rnd_bit());
            7'b1101111: step(P_JAL, ins, rnd_bit());
            7'b1100111: step(P_JALR, ins, rnd_bit());
            7'b0110111: step(P_LUI, ins, rnd_bit());
            7'b0010111: begin step(P_AUIPC, ins, rnd_bit()); step(P_ALU_WB, ins, rnd_bit()); end
            default:    step(P_ILLEGAL, ins, rnd_bit());
        endcase
    endtask

    // Monitor: compare the DUT control word against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e, g;
            int   ph;
            e  = exp_q.pop_front();
            ph = ph_q.pop_front();
            g  = '{st: state_o, pcw: pc_write, pcwc: pc_write_cond, pcs: pc_src,
                   irw: ir_write, mrd: mem_read, mwr: mem_write, rw: reg_write,
                   wb: wb_sel, a: alu_src_a, b: alu_src_b, aop: alu_op, fn: func,
                   ill: illegal_instr};
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL ctrl_word cycle %0d phase %0d instr %h: got %h required %h",
                          cyc, ph, instr, g, e);
        end
        cyc++;
    end

    localparam int N_OPS = 9;
    logic [6:0] op_tab [N_OPS] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111};

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        instr = 32'h0;
        mem_ready = 1'b0;
        // Two reset cycles; after the first edge the FSM must sit in FETCH
        @(posedge clk);
        #1;
        step(P_FETCH, 32'h0, 1'b0);
        rst = 1'b0;

        // Directed instructions from the plan
        run_instr(32'h002081B3, 0, 0);   // ADD
        run_instr(32'h402081B3, 0, 0);   // SUB  -> func 1000
        run_instr(32'h4030D093, 0, 0);   // SRAI -> func 1101
        run_instr(32'h00500093, 0, 0);   // ADDI -> func 0000
        run_instr(32'h40500093, 0, 0);   // ADDI with imm[10] set -> still 0000
        run_instr(32'h0040A283, 0, 3);   // LW, 3 wait cycles in MEM_RD
        run_instr(32'h0050A223, 2, 1);   // SW with fetch and write waits
        run_instr(32'h00209463, 0, 0);   // BNE
        run_instr(32'h008000EF, 1, 0);   // JAL
        run_instr(32'h000080E7, 0, 0);   // JALR
        run_instr(32'h123450B7, 0, 0);   // LUI
        run_instr(32'h00001097, 0, 0);   // AUIPC

        // Reset while a store is stalled in MEM_WR abandons it
        step(P_FETCH, 32'h0050A223, 1'b1);
        step(P_DECODE, 32'h0050A223, 1'b0);
        step(P_MEM_ADDR, 32'h0050A223, 1'b0);
        step(P_MEM_WR, 32'h0050A223, 1'b0);
        rst = 1'b1;
        step(P_MEM_WR, 32'h0050A223, 1'b0);
        rst = 1'b0;
        step(P_FETCH, 32'h0050A223, 1'b0);
        step(P_FETCH, 32'h0050A223, 1'b0);
        step(P_FETCH, 32'h0050A223, 1'b1);
        step(P_DECODE, 32'h0050A223, 1'b1);
        step(P_MEM_ADDR, 32'h0050A223, 1'b1);
        step(P_MEM_WR, 32'h0050A223, 1'b1);

        // Randomized instruction mix with random memory wait states
        for (int n = 0; n < 80; n++) begin
            r = $urandom;
            r[6:0] = op_tab[$urandom_range(0, N_OPS - 1)];
            run_instr(r, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Illegal opcode: trap-and-hold or 1-cycle NOP depending on build
        step(P_FETCH, 32'h0, 1'b1);
        step(P_DECODE, 32'h0, 1'b1);
        if (TRAP) begin
            for (int i = 0; i < 10; i++) step(P_ILLEGAL, 32'h0, rnd_bit());
            rst = 1'b1;
            step(P_ILLEGAL, 32'h0, 1'b0);
            rst = 1'b0;
        end else begin
            step(P_ILLEGAL, 32'h0, 1'b1);
        end
        step(P_FETCH, 32'h0, 1'b0);
        run_instr(32'h002081B3, 0, 0);

        // Every queued expectation must have been consumed by the monitor
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
